// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : 640x480@60Hz raster timing constants shared by the timing
//                generator and every renderer that consumes DrawX/DrawY.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Horizontal timing, in pixel clocks
  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  // Vertical timing, in lines
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Sync pulse windows, half-open [START, END)
  localparam int unsigned HS_START  = H_VISIBLE + H_FP;
  localparam int unsigned HS_END    = HS_START + H_SYNC;
  localparam int unsigned VS_START  = V_VISIBLE + V_FP;
  localparam int unsigned VS_END    = VS_START + V_SYNC;

  // Raster counter width (covers 0..1023)
  localparam int unsigned CNT_W     = 10;

  // Complete timing set, so a generator can be built for another mode
  typedef struct packed {
    logic [9:0] h_visible;
    logic [9:0] h_fp;
    logic [9:0] h_sync;
    logic [9:0] h_bp;
    logic [9:0] v_visible;
    logic [9:0] v_fp;
    logic [9:0] v_sync;
    logic [9:0] v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480 = '{
    h_visible: 10'(H_VISIBLE),
    h_fp:      10'(H_FP),
    h_sync:    10'(H_SYNC),
    h_bp:      10'(H_BP),
    v_visible: 10'(V_VISIBLE),
    v_fp:      10'(V_FP),
    v_sync:    10'(V_SYNC),
    v_bp:      10'(V_BP)
  };

  function automatic logic [9:0] h_total(input vga_timing_t t);
    return t.h_visible + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic logic [9:0] v_total(input vga_timing_t t);
    return t.v_visible + t.v_fp + t.v_sync + t.v_bp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_wrap_counter.sv
`default_nettype none
// ============================================================================
//  Module      : wrap_counter
//  Description : Enabled up-counter 0..MAX; wrap flags the enabled cycle in
//                which the count returns from MAX to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module wrap_counter #(
  parameter int             W   = 10,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign wrap = en && (count_q == MAX);

  // Next count: hold when disabled, return to zero past MAX
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = wrap ? '0 : count_q + ONE;
    end
  end

  // Count register, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : VGA raster timing generator. Column/row counters plus
//                registered sync/blank/frame decode aligned to DrawX/DrawY.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter vga_timing_t TIMING = VGA_640X480,
  parameter int          FCNT_W = 8
) (
  input  logic              vga_clk,
  input  logic              reset,
  output logic              hs,
  output logic              vs,
  output logic              blank,
  output logic              sync,
  output logic [9:0]        DrawX,
  output logic [9:0]        DrawY,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_count
);

  localparam logic [9:0] H_MAX       = h_total(TIMING) - 10'd1;
  localparam logic [9:0] V_MAX       = v_total(TIMING) - 10'd1;
  localparam logic [9:0] HSYNC_FIRST = TIMING.h_visible + TIMING.h_fp;
  localparam logic [9:0] HSYNC_END   = HSYNC_FIRST + TIMING.h_sync;
  localparam logic [9:0] VSYNC_FIRST = TIMING.v_visible + TIMING.v_fp;
  localparam logic [9:0] VSYNC_END   = VSYNC_FIRST + TIMING.v_sync;

  logic [9:0]        hc_q;
  logic [9:0]        vc_q;
  logic              h_wrap;
  logic              v_wrap;

  logic [9:0]        hc_d;
  logic [9:0]        vc_d;
  logic              hs_d;
  logic              vs_d;
  logic              blank_d;
  logic [FCNT_W-1:0] frame_count_d;

  logic              hs_q;
  logic              vs_q;
  logic              blank_q;
  logic              frame_start_q;
  logic [FCNT_W-1:0] frame_count_q;

  wrap_counter #(.W(10), .MAX(H_MAX)) u_hcnt (
    .clk   (vga_clk),
    .reset (reset),
    .en    (1'b1),
    .count (hc_q),
    .wrap  (h_wrap)
  );

  wrap_counter #(.W(10), .MAX(V_MAX)) u_vcnt (
    .clk   (vga_clk),
    .reset (reset),
    .en    (h_wrap),
    .count (vc_q),
    .wrap  (v_wrap)
  );

  // Decode from the counters' next values so the registered flags describe
  // the same pixel that DrawX/DrawY show in the following cycle
  always_comb begin
    hc_d          = h_wrap ? 10'd0 : hc_q + 10'd1;
    vc_d          = vc_q;
    if (h_wrap) begin
      vc_d        = v_wrap ? 10'd0 : vc_q + 10'd1;
    end
    hs_d          = !((hc_d >= HSYNC_FIRST) && (hc_d < HSYNC_END));
    vs_d          = !((vc_d >= VSYNC_FIRST) && (vc_d < VSYNC_END));
    blank_d       = (hc_d < TIMING.h_visible) && (vc_d < TIMING.v_visible);
    frame_count_d = frame_count_q + {{(FCNT_W-1){1'b0}}, v_wrap};
  end

  // Output registers; reset values describe pixel (0,0) without a frame pulse
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      frame_start_q <= v_wrap;
      frame_count_q <= frame_count_d;
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;
  assign sync        = 1'b0;

endmodule
`default_nettype wire
